// File: rtl/prog_loader_pkg.sv
// Shared constants for the UART program loader: FSM state codes, bit-timing helpers.
// Optional checksum state exists only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

  localparam int HDR_BYTES  = 2;
  localparam int DEF_CLK_HZ = 23_000_000;
  localparam int DEF_BAUD   = 128_000;

  // Cycles per UART bit, truncated toward zero.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int calc_half_div(input int div);
    return div / 2;
  endfunction

  localparam int DEF_DIV = calc_div(DEF_CLK_HZ, DEF_BAUD);

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_HDR0 = 3'd1;
  localparam state_t S_HDR1 = 3'd2;
  localparam state_t S_DATA = 3'd3;
  localparam state_t S_DONE = 3'd4;
  localparam state_t S_ERR  = 3'd5;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_CKSUM = 3'd6;
`endif

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t RX_IDLE  = 2'd0;
  localparam rx_state_t RX_START = 2'd1;
  localparam rx_state_t RX_DATA  = 2'd2;
  localparam rx_state_t RX_STOP  = 2'd3;

endpackage

// File: rtl/prog_uart_loader_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, glitch rejection
// on the start bit, one-cycle byte_valid_o / frame_err_o pulses.
module uart_rx_byte
  import prog_loader_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int HALF_DIV = calc_half_div(DIV);
  localparam int CNT_W    = $clog2(DIV + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t BIT_LAST  = cnt_t'(DIV - 1);
  localparam cnt_t HALF_LAST = cnt_t'(HALF_DIV - 1);

  logic      rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t state_q, state_d;
  cnt_t      cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic      byte_valid_q, byte_valid_d;
  logic      frame_err_q, frame_err_d;
  logic      fall;

  // Synchronizer flops reset to the idle-high line level so reset exit is not a start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall = rx_prev_q & ~rx_sync_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          state_d      = RX_IDLE;
          cnt_d        = '0;
          byte_valid_d = rx_sync_q;
          frame_err_d  = ~rx_sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/prog_uart_loader.sv
// Loads a length-prefixed little-endian program image from UART into instruction memory.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_uart_loader
  import prog_loader_pkg::*;
#(
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int BAUD      = DEF_BAUD,
  parameter int ADDR_W    = 14,
  parameter int MAX_WORDS = 16384
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              rx,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [31:0]       prog_wdata,
  output logic              loading,
  output logic              done,
  output logic              err
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CKSUM;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clock        (clock),
    .reset        (reset),
    .rx_i         (rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr)
  );

  state_t              state_q, state_d;
  logic [15:0]         n_words_q, n_words_d;
  logic [1:0]          lane_q, lane_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [23:0]         asm_q, asm_d;
  logic                prog_we_q, prog_we_d;
  logic [ADDR_W-1:0]   prog_addr_q, prog_addr_d;
  logic [31:0]         prog_wdata_q, prog_wdata_d;
  logic                loading_q, done_q, err_q;
  logic [15:0]         hdr_n;
  logic                last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          cksum_q, cksum_d;
`endif

  assign hdr_n     = {rx_byte, n_words_q[7:0]};
  assign last_word = (17'(word_idx_q) == (17'(n_words_q) - 17'd1));

  always_comb begin
    state_d      = state_q;
    n_words_d    = n_words_q;
    lane_d       = lane_q;
    word_idx_d   = word_idx_q;
    asm_d        = asm_q;
    prog_we_d    = 1'b0;
    prog_addr_d  = prog_addr_q;
    prog_wdata_d = prog_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    cksum_d      = cksum_q;
    if (rx_valid) cksum_d = cksum_q ^ rx_byte;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR0;
          lane_d     = '0;
          word_idx_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          cksum_d    = '0;
`endif
        end
      end
      S_HDR0: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          n_words_d[7:0] = rx_byte;
          state_d        = S_HDR1;
        end
      end
      S_HDR1: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          n_words_d = hdr_n;
          if (hdr_n == 16'd0)                      state_d = S_AFTER_DATA;
          else if (17'(hdr_n) > 17'(MAX_WORDS))    state_d = S_ERR;
          else                                     state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          if (lane_q == 2'd3) begin
            prog_we_d    = 1'b1;
            prog_addr_d  = word_idx_q;
            prog_wdata_d = {rx_byte, asm_q};
            lane_d       = '0;
            word_idx_d   = word_idx_q + 1'b1;
            if (last_word) state_d = S_AFTER_DATA;
          end else begin
            asm_d[8*lane_q +: 8] = rx_byte;
            lane_d               = lane_q + 1'b1;
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CKSUM: begin
        if (rx_ferr)       state_d = S_ERR;
        else if (rx_valid) state_d = (rx_byte == cksum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      n_words_q    <= '0;
      lane_q       <= '0;
      word_idx_q   <= '0;
      asm_q        <= '0;
      prog_we_q    <= 1'b0;
      prog_addr_q  <= '0;
      prog_wdata_q <= '0;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_words_q    <= n_words_d;
      lane_q       <= lane_d;
      word_idx_q   <= word_idx_d;
      asm_q        <= asm_d;
      prog_we_q    <= prog_we_d;
      prog_addr_q  <= prog_addr_d;
      prog_wdata_q <= prog_wdata_d;
      // Status flags track the state being entered, so they change with the write strobe.
      loading_q    <= (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA)
`ifdef PROG_LOADER_CHECKSUM_EN
                      || (state_d == S_CKSUM)
`endif
                      ;
      done_q       <= (state_d == S_DONE);
      err_q        <= (state_d == S_ERR);
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cksum_q <= '0;
    else        cksum_q <= cksum_d;
  end
`endif

  assign prog_we    = prog_we_q;
  assign prog_addr  = prog_addr_q;
  assign prog_wdata = prog_wdata_q;
  assign loading    = loading_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_uart_loader.sv
// Self-checking bench for prog_uart_loader: vector table, corner sequences and random images.
module tb_prog_uart_loader;

  localparam int CLK_HZ    = 16_000_000;
  localparam int BAUD      = 1_000_000;
  localparam int ADDR_W    = 14;
  localparam int MAX_WORDS = 8;
  localparam int DIV       = CLK_HZ / BAUD;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              rx    = 1'b1;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_wdata;
  logic              loading, done, err;

  always #5 clock = ~clock;

  prog_uart_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .rx         (rx),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .loading    (loading),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    string        name;
    int           nbytes;
    logic [79:0]  bytes;    // byte 0 in the top 8 bits
    int           bad_idx;  // byte sent with a 0 stop bit, -1 for none
    bit           exp_done;
    bit           exp_err;
    int           exp_nw;
  } vec_t;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  bit         exp_done, exp_err;
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(negedge clock) begin
    if (prog_we) got_q.push_back({prog_addr, prog_wdata});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clock) rx = 1'b0;
    repeat (DIV) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clock);
    end
    rx = stop_bit;
    repeat (DIV) @(negedge clock);
    rx = 1'b1;
    repeat (DIV) @(negedge clock);
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  // Reference: what the image in tx_q should produce, from the framing rules alone.
  task automatic model(input int bad_idx, input bit cksum_bad);
    int n, words;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (bad_idx >= 0 && bad_idx < 2) begin
      exp_err = 1'b1;
    end else begin
      n = int'({tx_q[1], tx_q[0]});
      if (n > MAX_WORDS) begin
        exp_err = 1'b1;
      end else begin
        words = n;
        if (bad_idx >= 0 && bad_idx < 2 + 4 * n) begin
          words   = (bad_idx - 2) / 4;
          exp_err = 1'b1;
        end else begin
          exp_done = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          if (cksum_bad) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
          end
`endif
        end
        for (int k = 0; k < words; k++)
          exp_q.push_back({ADDR_W'(k), tx_q[2+4*k+3], tx_q[2+4*k+2], tx_q[2+4*k+1], tx_q[2+4*k]});
      end
    end
    if (cksum_bad && !exp_err) exp_err = 1'b0;
  endtask

  task automatic run_image(input string name, input int bad_idx, input bit cksum_bad);
    int         t;
    logic [7:0] x;
    model(bad_idx, cksum_bad);
    got_q.delete();
    pulse_start();
    x = 8'h00;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (bad_idx >= 0 && i > bad_idx) break;
      x ^= tx_q[i];
      send_byte(tx_q[i], (i == bad_idx) ? 1'b0 : 1'b1);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (bad_idx < 0) send_byte(cksum_bad ? ~x : x, 1'b1);
`endif
    t = 0;
    while (!(done || err) && t < 200) begin
      @(negedge clock);
      t++;
    end
    check({name, " finished"}, 64'(done | err), 64'd1);
    check({name, " done"}, 64'(done), 64'(exp_done));
    check({name, " err"}, 64'(err), 64'(exp_err));
    check({name, " loading"}, 64'(loading), 64'd0);
    check({name, " writes"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s addr[%0d]", name, i), 64'(got_q[i].addr), 64'(exp_q[i].addr));
      check($sformatf("%s data[%0d]", name, i), 64'(got_q[i].data), 64'(exp_q[i].data));
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"nominal",    10, 80'h0200_1300_0000_FFFF_FFFF, -1, 1'b1, 1'b0, 2};
    vecs[1] = '{"empty",       2, 80'h0000_0000_0000_0000_0000, -1, 1'b1, 1'b0, 0};
    vecs[2] = '{"frame_data",  3, 80'h0100_5A00_0000_0000_0000,  2, 1'b0, 1'b1, 0};
    vecs[3] = '{"recover",     6, 80'h0100_7856_3412_0000_0000, -1, 1'b1, 1'b0, 1};
    vecs[4] = '{"oversize",    2, 80'h0900_0000_0000_0000_0000, -1, 1'b0, 1'b1, 0};
    vecs[5] = '{"frame_word2", 8, 80'h0200_1122_3344_5566_0000,  7, 1'b0, 1'b1, 1};
    vecs[6] = '{"frame_hdr1",  2, 80'h0100_0000_0000_0000_0000,  1, 1'b0, 1'b1, 0};

    // Reset held with a noisy line: everything stays at its reset value.
    for (int i = 0; i < 40; i++) begin
      @(negedge clock) rx = 1'($urandom);
    end
    check("rst prog_we", 64'(prog_we), 64'd0);
    check("rst prog_addr", 64'(prog_addr), 64'd0);
    check("rst prog_wdata", 64'(prog_wdata), 64'd0);
    check("rst loading", 64'(loading), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst err", 64'(err), 64'd0);
    check("rst writes", 64'(got_q.size()), 64'd0);
    rx = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // Bytes without a start are ignored.
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h13 + 8'(i), 1'b1);
    check("no start writes", 64'(got_q.size()), 64'd0);
    check("no start loading", 64'(loading), 64'd0);
    check("no start done", 64'(done), 64'd0);

    // Quarter-bit glitch while idle.
    @(negedge clock) rx = 1'b0;
    repeat (DIV / 4) @(negedge clock);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clock);
    check("idle glitch err", 64'(err), 64'd0);

    for (int v = 0; v < 7; v++) begin
      tx_q.delete();
      for (int i = 0; i < vecs[v].nbytes; i++) tx_q.push_back(vecs[v].bytes[79-8*i -: 8]);
      run_image(vecs[v].name, vecs[v].bad_idx, 1'b0);
      check({vecs[v].name, " tbl done"}, 64'(done), 64'(vecs[v].exp_done));
      check({vecs[v].name, " tbl err"}, 64'(err), 64'(vecs[v].exp_err));
      check({vecs[v].name, " tbl writes"}, 64'(got_q.size()), 64'(vecs[v].exp_nw));
    end

    // Glitch in HDR0; the later start inside run_image is ignored because loading is high.
    got_q.delete();
    pulse_start();
    @(negedge clock) rx = 1'b0;
    repeat (DIV / 4) @(negedge clock);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clock);
    check("hdr0 glitch err", 64'(err), 64'd0);
    check("hdr0 glitch loading", 64'(loading), 64'd1);
    tx_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_image("after_glitch", -1, 1'b0);

    // Exactly MAX_WORDS words is accepted.
    tx_q = '{8'(MAX_WORDS), 8'h00};
    for (int i = 0; i < 4 * MAX_WORDS; i++) tx_q.push_back(8'($urandom));
    run_image("max_words", -1, 1'b0);

    // Reset mid-load aborts; trailing bytes write nothing.
    got_q.delete();
    pulse_start();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    @(negedge clock) reset = 1'b0;
    repeat (3) @(negedge clock);
    check("midrst loading", 64'(loading), 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) send_byte(8'h30 + 8'(i), 1'b1);
    check("midrst writes", 64'(got_q.size()), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst err", 64'(err), 64'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_image("cksum_bad", -1, 1'b1);
`endif

    // Random images against the reference model.
    for (int r = 0; r < 12; r++) begin
      int n, bad;
      bad = -1;
      if ($urandom_range(5) == 0) begin
        n = MAX_WORDS + 1 + int'($urandom_range(3));
        tx_q = '{8'(n), 8'(n >> 8)};
      end else begin
        n = int'($urandom_range(1, 4));
        tx_q = '{8'(n), 8'h00};
        for (int i = 0; i < 4 * n; i++) tx_q.push_back(8'($urandom));
        if ($urandom_range(4) == 0) bad = int'($urandom_range(2, 1 + 4 * n));
      end
      run_image($sformatf("rand%0d", r), bad, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_uart_loader.md
Name: prog_uart_loader

Overview:
- Writer side of the instruction memory.
- Receives a program image over a UART serial line, assembles little-endian bytes into 32-bit instruction words, and issues one-cycle word writes into the program ROM port read by the fetch unit.
- The word address is PC[15:2] granularity, so word k lands at PC = 4k.
- Sits beside the fetch unit; the CPU is held off (via `loading`) while an image is being written.

Parameters:
- CLK_HZ, 23000000, system clock frequency in Hz
- BAUD, 128000, UART bit rate; DIV = CLK_HZ/BAUD cycles per bit (integer, truncated)
- ADDR_W, 14, instruction-memory word-address width
- MAX_WORDS, 16384, largest accepted image in words (must be <= 2**ADDR_W)

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  single-cycle pulse: arm the loader for a new image
- rx  input  1  UART serial line, idle high, 8N1, LSB first; asynchronous to clock
- prog_we  output  1  one-cycle write strobe to program memory
- prog_addr  output  ADDR_W  word address for the write
- prog_wdata  output  32  instruction word for the write
- loading  output  1  high from accepted start until DONE or ERR
- done  output  1  sticky: image fully written; cleared by the next start
- err  output  1  sticky: framing error, oversize image or checksum mismatch; cleared by the next start

Behaviour:
- Reset values: prog_we=0, prog_addr=0, prog_wdata=0, loading=0, done=0, err=0, FSM=IDLE, byte/word counters=0. Reset asserted mid-load aborts immediately; no further writes occur.
- rx passes through a 2-flop synchronizer, which adds 2 cycles of latency.
- Byte receiver:
  - Idle until a synchronized falling edge on rx.
  - Waits DIV/2 cycles and re-samples; if rx is high, the start bit is treated as a glitch and the receiver returns to idle with no error.
  - Samples 8 data bits every DIV cycles, then the stop bit.
  - Stop bit = 0 is a framing error.
  - Emits byte_valid for one cycle after the stop-bit sample.
- FSM states: IDLE, HDR0, HDR1, DATA, CKSUM (macro only), DONE, ERR.
  - IDLE: start -> HDR0, set loading=1, clear done/err, word index=0, byte lane=0. Bytes arriving in IDLE are ignored.
  - HDR0: byte -> N[7:0] -> HDR1.
  - HDR1: byte -> N[15:8].
    - N=0: go to DONE (or CKSUM).
    - N>MAX_WORDS: go to ERR.
    - Otherwise: go to DATA.
  - DATA:
    - Byte lane b (0..3) fills word bits [8b+7:8b].
    - On lane 3, in the cycle after byte_valid: prog_we=1 for exactly one cycle, prog_addr=word index, prog_wdata=assembled word. Word index then increments and lane resets to 0.
    - After word N-1 is written: go to DONE (or CKSUM).
  - DONE: loading=0, done=1; stays until start.
  - ERR: loading=0, err=1; stays until start; no further writes.
- A framing error in any receiving state goes to ERR.
- start while loading=1 is ignored.
- start coincident with byte_valid in IDLE: the FSM enters HDR0; that byte is discarded.
- Word index never wraps: the N<=MAX_WORDS check guarantees this.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN
- Defined:
  - After the last data byte, the FSM enters CKSUM and receives one byte.
  - If that byte equals the XOR of all header and data bytes, go to DONE; otherwise go to ERR.
  - Data words are still written before the check.
- Undefined: the CKSUM state and XOR accumulator are absent; the FSM goes directly to DONE after the last word.

Decomposition:
- Package prog_loader_pkg: FSM state enum, derived DIV and DIV/2 constants, header byte count (2).
- One sub-module: uart_rx_byte (synchronizer, bit timer, shift register, byte_valid, frame_err).
- The loader FSM, assembler and address counter live in prog_uart_loader.

Test Plan:
- Reset: hold reset=0 with rx toggling -> all outputs 0; release, no start -> no prog_we ever.
- Nominal load: start, send 02 00 13 00 00 00 FF FF FF FF -> prog_we at addr 0 data 0x00000013, then addr 1 data 0xFFFFFFFF, done=1, loading=0.
- Empty image: start, send 00 00 -> done=1 with zero prog_we pulses.
- Framing error: start, send 01 00 then a byte with stop bit 0 -> err=1, loading=0, no write. A subsequent start plus a valid image clears err and loads correctly.
- Oversize and glitch:
  - Header N=MAX_WORDS+1 -> err=1 immediately after HDR1.
  - A 0.25-bit low pulse on rx in IDLE/HDR0 -> no byte accepted, no error.
- Checksum (macro defined): image 01 00 AA BB CC DD with checksum byte 0x01 -> write 0xDDCCBBAA then done. The same image with checksum 0x00 -> write occurs, then err=1.
